// File: rtl/rowcache_miss_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rowcache_miss_ctrl
// Purpose  : Row-cache miss handler. Owns the tag/LRU table, picks a victim,
//            writes it back if dirty, fills the requested row, pulses sync.
// Revision : 1.0  initial release
// ============================================================================
module rowcache_miss_ctrl #(
  parameter int CHWIDTH   = 5,
  parameter int ADDRWIDTH = 17
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 miss_req,
  input  logic [ADDRWIDTH-1:0] miss_rowid,
  input  logic                 access_valid,
  input  logic [CHWIDTH-1:0]   access_crow,
  input  logic                 access_wr,
  output logic                 sync,
  output logic [CHWIDTH-1:0]   fill_crow,
  output logic                 busy,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [ADDRWIDTH-1:0] mem_rowid,
  output logic [CHWIDTH-1:0]   mem_crow,
  input  logic                 mem_ack
);
  localparam int                 c_CHROWS  = 2 ** CHWIDTH;
  localparam logic [CHWIDTH-1:0] c_AGE_MAX = CHWIDTH'(c_CHROWS - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SELECT = 3'd1,
    ST_WB     = 3'd2,
    ST_FILL   = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  state_t                 r_state, w_state_nxt;
  logic                   r_miss_q;
  logic [ADDRWIDTH-1:0]   r_rowid;
  logic [CHWIDTH-1:0]     r_victim, w_victim_nxt;
  logic [c_CHROWS-1:0]    r_valid, r_dirty;
  logic [ADDRWIDTH-1:0]   r_rowaddr [c_CHROWS];
  logic [CHWIDTH-1:0]     r_age     [c_CHROWS];
  logic [CHWIDTH-1:0]     w_age_nxt [c_CHROWS];
  logic                   r_mem_req, w_req_nxt;
  logic                   r_mem_we, w_we_nxt;
  logic [ADDRWIDTH-1:0]   r_mem_rowid, w_rowid_nxt;
  logic [CHWIDTH-1:0]     r_mem_crow, w_crow_nxt;
  logic                   w_start, w_hit, w_free;
  logic [CHWIDTH-1:0]     w_hit_row, w_free_row, w_lru_row, w_miss_row;
  logic                   w_touch_en, w_set_dirty, w_install;
  logic [CHWIDTH-1:0]     w_touch_row, w_touch_age;

  assign w_start    = (r_state == ST_IDLE) && miss_req && !r_miss_q;
  assign w_miss_row = w_free ? w_free_row : w_lru_row;

  assign busy      = (r_state != ST_IDLE);
  assign sync      = (r_state == ST_DONE);
  assign fill_crow = (r_state == ST_DONE) ? r_victim : '0;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_rowid = r_mem_rowid;
  assign mem_crow  = r_mem_crow;

  // Scanning downwards leaves the lowest matching index in each candidate.
  always_comb begin
    w_hit      = 1'b0;
    w_hit_row  = '0;
    w_free     = 1'b0;
    w_free_row = '0;
    w_lru_row  = '0;
    for (int i = c_CHROWS - 1; i >= 0; i--) begin
      if (r_valid[i] && (r_rowaddr[i] == r_rowid)) begin
        w_hit     = 1'b1;
        w_hit_row = CHWIDTH'(i);
      end
      if (!r_valid[i]) begin
        w_free     = 1'b1;
        w_free_row = CHWIDTH'(i);
      end
      if (r_age[i] == c_AGE_MAX) w_lru_row = CHWIDTH'(i);
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_victim_nxt = r_victim;
    w_req_nxt    = r_mem_req;
    w_we_nxt     = r_mem_we;
    w_rowid_nxt  = r_mem_rowid;
    w_crow_nxt   = r_mem_crow;
    w_touch_en   = 1'b0;
    w_touch_row  = access_crow;
    w_set_dirty  = 1'b0;
    w_install    = 1'b0;
    if ((r_state != ST_DONE) && access_valid) begin
      w_touch_en  = 1'b1;
      // the victim's dirty bit belongs to the transfer in flight
      w_set_dirty = access_wr && !(((r_state == ST_WB) || (r_state == ST_FILL)) &&
                                   (access_crow == r_victim));
    end
    case (r_state)
      ST_IDLE: if (w_start) w_state_nxt = ST_SELECT;
      ST_SELECT: begin
        if (w_hit) begin
          w_victim_nxt = w_hit_row;
          w_state_nxt  = ST_DONE;
        end else begin
          w_victim_nxt = w_miss_row;
          w_req_nxt    = 1'b1;
          w_crow_nxt   = w_miss_row;
          if (!w_free && r_dirty[w_lru_row]) begin
            w_state_nxt = ST_WB;
            w_we_nxt    = 1'b1;
            w_rowid_nxt = r_rowaddr[w_lru_row];
          end else begin
            w_state_nxt = ST_FILL;
            w_we_nxt    = 1'b0;
            w_rowid_nxt = r_rowid;
          end
        end
      end
      ST_WB: begin
        if (r_mem_req && mem_ack) begin
          w_req_nxt   = 1'b0;
          w_state_nxt = ST_FILL;
        end
      end
      ST_FILL: begin
        if (!r_mem_req) begin
          w_req_nxt   = 1'b1;
          w_we_nxt    = 1'b0;
          w_rowid_nxt = r_rowid;
          w_crow_nxt  = r_victim;
        end else if (mem_ack) begin
          w_req_nxt   = 1'b0;
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
        w_touch_en  = 1'b1;
        w_touch_row = r_victim;
        w_install   = 1'b1;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_touch_age = r_age[w_touch_row];
    for (int i = 0; i < c_CHROWS; i++) begin
      w_age_nxt[i] = r_age[i];
      if (w_touch_en) begin
        if (CHWIDTH'(i) == w_touch_row)  w_age_nxt[i] = '0;
        else if (r_age[i] < w_touch_age) w_age_nxt[i] = r_age[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_miss_q    <= 1'b0;
      r_rowid     <= '0;
      r_victim    <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_rowid <= '0;
      r_mem_crow  <= '0;
      r_valid     <= '0;
      r_dirty     <= '0;
      for (int i = 0; i < c_CHROWS; i++) begin
        r_rowaddr[i] <= '0;
        r_age[i]     <= CHWIDTH'(i);
      end
    end else begin
      r_miss_q    <= miss_req;
      if (w_start) r_rowid <= miss_rowid;
      r_victim    <= w_victim_nxt;
      r_mem_req   <= w_req_nxt;
      r_mem_we    <= w_we_nxt;
      r_mem_rowid <= w_rowid_nxt;
      r_mem_crow  <= w_crow_nxt;
      for (int i = 0; i < c_CHROWS; i++) r_age[i] <= w_age_nxt[i];
      if (w_set_dirty) r_dirty[access_crow] <= 1'b1;
      if (w_install) begin
        r_valid[r_victim]   <= 1'b1;
        r_dirty[r_victim]   <= 1'b0;
        r_rowaddr[r_victim] <= r_rowid;
      end
    end
  end
endmodule
`default_nettype wire
